// File: rtl/iob_nco_period_meter_pkg.sv
// Shared definitions for the NCO period meter: FSM state encoding and its width.
package iob_nco_period_meter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } meter_state_t;

endpackage

// File: rtl/iob_nco_period_meter_sync.sv
// SYNC_N-stage synchronizer that brings the asynchronous measured signal into the clk_i domain.
module iob_nco_period_meter_sync #(
    parameter int SYNC_N = 2
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic sync_o
);

    logic [SYNC_N-1:0] r_stages;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stages <= '0;
        end else if (cke_i) begin
            r_stages <= {r_stages[SYNC_N-2:0], sig_i};
        end
    end

    assign sync_o = r_stages[SYNC_N-1];

endmodule

// File: rtl/iob_nco_period_meter.sv
// Measures a slow clock-like signal in clk_i cycles: counts whole periods inside a gate window
// and reports total cycles and edge count so the host can compute the mean period.
module iob_nco_period_meter
    import iob_nco_period_meter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SYNC_N = 2
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              sig_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] gate_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_o,
    output logic              timeout_o,
    output logic              ovf_o,
    output logic [DATA_W-1:0] cycles_o,
    output logic [DATA_W-1:0] edges_o
);

    meter_state_t r_state;
    meter_state_t w_stateNext;

    logic              w_sync;
    logic              r_syncD;
    logic              w_rise;
    logic [DATA_W-1:0] r_gate;
    logic [DATA_W-1:0] r_tmoCnt;
    logic [DATA_W-1:0] r_gCnt;
    logic [DATA_W-1:0] r_cyc;
    logic [DATA_W-1:0] r_edg;
    logic [DATA_W-1:0] r_last;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic              r_timeout;
    logic              r_ovf;
    logic [DATA_W-1:0] r_cyclesOut;
    logic [DATA_W-1:0] r_edgesOut;

    logic              w_accept;
    logic              w_armRise;
    logic              w_armTmo;
    logic              w_measEnd;
    logic [DATA_W-1:0] w_gateEff;
    logic [DATA_W-1:0] w_tmoInc;
    logic [DATA_W-1:0] w_gCntInc;
    logic              w_cycSat;
    logic [DATA_W-1:0] w_cycInc;
    logic [DATA_W-1:0] w_edgNext;
    logic [DATA_W-1:0] w_lastNext;

    iob_nco_period_meter_sync #(
        .SYNC_N (SYNC_N)
    ) u_sync (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .rst_i  (rst_i),
        .sig_i  (sig_i),
        .sync_o (w_sync)
    );

    assign w_rise    = w_sync & ~r_syncD;
    assign w_gateEff = (gate_i == '0) ? DATA_W'(1) : gate_i;
    assign w_tmoInc  = r_tmoCnt + DATA_W'(1);
    assign w_gCntInc = r_gCnt + DATA_W'(1);
    assign w_cycSat  = (r_cyc == '1);
    assign w_cycInc  = w_cycSat ? r_cyc : r_cyc + DATA_W'(1);
    // The last snapshot is the post-increment cycle count, so it equals the gate index of that rise.
    assign w_edgNext  = !w_rise ? r_edg : ((r_edg == '1) ? r_edg : r_edg + DATA_W'(1));
    assign w_lastNext = w_rise ? w_cycInc : r_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else if (cke_i) begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_armRise   = 1'b0;
        w_armTmo    = 1'b0;
        w_measEnd   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_stateNext = ST_ARM;
                end
            end
            ST_ARM: begin
                // A rise wins over an arm timeout landing on the same cycle.
                if (w_rise) begin
                    w_armRise   = 1'b1;
                    w_stateNext = ST_MEAS;
                end else if (w_tmoInc == r_gate) begin
                    w_armTmo    = 1'b1;
                    w_stateNext = ST_DONE;
                end
            end
            ST_MEAS: begin
                if (w_gCntInc == r_gate) begin
                    w_measEnd   = 1'b1;
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_syncD     <= 1'b0;
            r_gate      <= '0;
            r_tmoCnt    <= '0;
            r_gCnt      <= '0;
            r_cyc       <= '0;
            r_edg       <= '0;
            r_last      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_ovf       <= 1'b0;
            r_cyclesOut <= '0;
            r_edgesOut  <= '0;
        end else if (cke_i) begin
            r_syncD <= w_sync;
            r_busy  <= (w_stateNext == ST_ARM) || (w_stateNext == ST_MEAS);
            r_done  <= 1'b0;
            if (w_accept) begin
                r_gate    <= w_gateEff;
                r_tmoCnt  <= '0;
                r_valid   <= 1'b0;
                r_timeout <= 1'b0;
                r_ovf     <= 1'b0;
            end
            if (r_state == ST_ARM) begin
                r_tmoCnt <= w_tmoInc;
            end
            if (w_armRise) begin
                r_cyc  <= '0;
                r_edg  <= '0;
                r_gCnt <= '0;
                r_last <= '0;
            end
            if (r_state == ST_MEAS) begin
                r_gCnt <= w_gCntInc;
                r_cyc  <= w_cycInc;
                r_edg  <= w_edgNext;
                r_last <= w_lastNext;
                if (w_cycSat) begin
                    r_ovf <= 1'b1;
                end
            end
            // No period completed inside the window reports as a timeout with zeroed results.
            if (w_armTmo || w_measEnd) begin
                r_done  <= 1'b1;
                r_valid <= 1'b1;
                if (w_armTmo || (w_edgNext == '0)) begin
                    r_timeout   <= 1'b1;
                    r_cyclesOut <= '0;
                    r_edgesOut  <= '0;
                end else begin
                    r_cyclesOut <= w_lastNext;
                    r_edgesOut  <= w_edgNext;
                end
            end
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;
    assign ovf_o     = r_ovf;
    assign cycles_o  = r_cyclesOut;
    assign edges_o   = r_edgesOut;

endmodule

// File: tb/tb_iob_nco_period_meter.sv
// Self-checking bench for iob_nco_period_meter: directed scenarios plus randomized waveforms
// compared against a rise-list reference model.
module tb_iob_nco_period_meter;

    logic        clk_i = 1'b0;
    logic        cke_i;
    logic        rst_i;
    logic        sig_i;
    logic        start_i;
    logic [31:0] gate_i;
    logic [7:0]  gate8;

    logic        busy, done, valid, tmo, ovf;
    logic [31:0] cyc, edg;
    logic        busy8, done8, valid8, tmo8, ovf8;
    logic [7:0]  cyc8, edg8;

    int  nChecks = 0;
    int  nFails  = 0;
    bit  waveMem [0:4095];
    bit  waveRun = 1'b0;

    always #5 clk_i = ~clk_i;

    iob_nco_period_meter #(.DATA_W(32), .SYNC_N(2)) u_dut (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .sig_i(sig_i), .start_i(start_i),
        .gate_i(gate_i), .busy_o(busy), .done_o(done), .valid_o(valid), .timeout_o(tmo),
        .ovf_o(ovf), .cycles_o(cyc), .edges_o(edg)
    );

    iob_nco_period_meter #(.DATA_W(8), .SYNC_N(2)) u_dut8 (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .sig_i(sig_i), .start_i(start_i),
        .gate_i(gate8), .busy_o(busy8), .done_o(done8), .valid_o(valid8), .timeout_o(tmo8),
        .ovf_o(ovf8), .cycles_o(cyc8), .edges_o(edg8)
    );

    // Plays the waveform one sample per enabled clock, pausing whenever the clock enable is low.
    initial begin
        int idx;
        idx   = 0;
        sig_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (waveRun) begin
                if (cke_i) begin
                    sig_i = (idx < 4096) ? waveMem[idx] : 1'b0;
                    idx++;
                end
            end else begin
                sig_i = 1'b0;
                idx   = 0;
            end
        end
    end

    task automatic buildPeriodic(input int lead, input int hi, input int lo);
        int i;
        i = 0;
        while (i < 4096) begin
            if (i < lead) waveMem[i] = 1'b0;
            else waveMem[i] = (((i - lead) % (hi + lo)) < hi);
            i++;
        end
    endtask

    task automatic buildRandom(input int lead, input int maxHalf);
        int i, hi, lo;
        i = 0;
        while (i < 4096) begin
            if (i < lead) begin
                waveMem[i] = 1'b0;
                i++;
            end else begin
                hi = $urandom_range(maxHalf, 1);
                lo = $urandom_range(maxHalf, 1);
                for (int k = 0; k < hi + lo && i < 4096; k++) begin
                    waveMem[i] = (k < hi);
                    i++;
                end
            end
        end
    endtask

    // Reference: list every rising edge of the waveform, then count those whose distance
    // from the first one lies in (0, G]; the furthest such distance is the cycle total.
    task automatic modelMeasure(input int g, output int expEdges, output int expCycles, output bit expTmo);
        int  rises[$];
        bit  prev;
        int  gEff, d;
        gEff = (g == 0) ? 1 : g;
        prev = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            if (waveMem[i] && !prev) rises.push_back(i);
            prev = waveMem[i];
        end
        expEdges  = 0;
        expCycles = 0;
        if (rises.size() > 0) begin
            foreach (rises[j]) begin
                d = rises[j] - rises[0];
                if (d > 0 && d <= gEff) begin
                    expEdges++;
                    expCycles = d;
                end
            end
        end
        expTmo = (expEdges == 0);
        if (expTmo) expCycles = 0;
    endtask

    task automatic applyStimulus(input int g);
        @(negedge clk_i);
        start_i = 1'b1;
        gate_i  = g;
        gate8   = g[7:0];
        waveRun = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic waitDone(input bit use8, input int budget, output int waited, output bit seen);
        seen   = 1'b0;
        waited = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk_i);
            if (use8 ? done8 : done) begin
                seen   = 1'b1;
                waited = n;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        waveRun = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset;
        cke_i   = 1'b1;
        rst_i   = 1'b1;
        start_i = 1'b0;
        gate_i  = '0;
        gate8   = '0;
        repeat (3) @(negedge clk_i);
        nChecks++;
        if ({busy, done, valid, tmo, ovf} !== 5'b0) begin
            nFails++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, valid, tmo, ovf});
        end
        nChecks++;
        if (cyc !== 32'd0 || edg !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL reset_counts: got cycles=%0d edges=%0d expected 0/0", cyc, edg);
        end
        rst_i = 1'b0;
        idle(2);
    endtask

    task automatic test_basic(input string tag);
        int  waited;
        bit  seen;
        buildPeriodic(3, 5, 5);
        applyStimulus(100);
        nChecks++;
        if (busy !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL %s_busy: got %b expected 1", tag, busy);
        end
        waitDone(1'b0, 400, waited, seen);
        nChecks++;
        if (!seen || edg !== 32'd10 || cyc !== 32'd100 || tmo !== 1'b0 || valid !== 1'b1 || ovf !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL %s_result: got done=%b edges=%0d cycles=%0d tmo=%b valid=%b ovf=%b expected 1/10/100/0/1/0",
                     tag, seen, edg, cyc, tmo, valid, ovf);
        end
        @(negedge clk_i);
        nChecks++;
        if (done !== 1'b0 || valid !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL %s_pulse: got done=%b valid=%b expected 0/1", tag, done, valid);
        end
        idle(6);
    endtask

    task automatic test_pattern;
        int  waited;
        bit  seen;
        int  i;
        i = 0;
        while (i < 4096) begin
            waveMem[i] = (i >= 2) && (((i - 2) % 5) == 0 || ((i - 2) % 5) == 2);
            i++;
        end
        applyStimulus(100);
        waitDone(1'b0, 400, waited, seen);
        nChecks++;
        if (!seen || edg !== 32'd40 || cyc !== 32'd100 || tmo !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL pattern_2_3: got done=%b edges=%0d cycles=%0d tmo=%b expected 1/40/100/0",
                     seen, edg, cyc, tmo);
        end
        idle(6);
    endtask

    task automatic test_arm_timeout;
        int  waited;
        bit  seen;
        for (int i = 0; i < 4096; i++) waveMem[i] = 1'b0;
        applyStimulus(50);
        waitDone(1'b0, 200, waited, seen);
        nChecks++;
        if (!seen || waited != 50) begin
            nFails++;
            $display("[TB] FAIL arm_latency: got done=%b after %0d cycles expected 50", seen, waited);
        end
        nChecks++;
        if (tmo !== 1'b1 || edg !== 32'd0 || cyc !== 32'd0 || valid !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL arm_timeout: got tmo=%b edges=%0d cycles=%0d valid=%b expected 1/0/0/1",
                     tmo, edg, cyc, valid);
        end
        idle(6);
        applyStimulus(0);
        waitDone(1'b0, 50, waited, seen);
        nChecks++;
        if (!seen || waited != 1 || tmo !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL gate_zero: got done=%b after %0d cycles tmo=%b expected done after 1, tmo=1",
                     seen, waited, tmo);
        end
        idle(6);
    endtask

    task automatic test_narrow;
        int  waited;
        bit  seen;
        buildPeriodic(2, 150, 150);
        applyStimulus(255);
        waitDone(1'b1, 700, waited, seen);
        nChecks++;
        if (!seen || tmo8 !== 1'b1 || edg8 !== 8'd0 || cyc8 !== 8'd0) begin
            nFails++;
            $display("[TB] FAIL narrow_long_period: got done=%b tmo=%b edges=%0d cycles=%0d expected 1/1/0/0",
                     seen, tmo8, edg8, cyc8);
        end
        idle(6);
        buildPeriodic(2, 3, 4);
        applyStimulus(255);
        waitDone(1'b1, 700, waited, seen);
        nChecks++;
        if (!seen || tmo8 !== 1'b0 || ovf8 !== 1'b0 || edg8 !== 8'd36 || cyc8 !== 8'd252) begin
            nFails++;
            $display("[TB] FAIL narrow_period7: got done=%b tmo=%b ovf=%b edges=%0d cycles=%0d expected 1/0/0/36/252",
                     seen, tmo8, ovf8, edg8, cyc8);
        end
        idle(6);
    endtask

    task automatic test_reset_mid;
        int  doneCount;
        buildPeriodic(3, 5, 5);
        applyStimulus(100);
        repeat (30) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        nChecks++;
        if ({busy, done, valid, tmo, ovf} !== 5'b0 || cyc !== 32'd0 || edg !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL mid_reset: got flags=%b cycles=%0d edges=%0d expected all zero",
                     {busy, done, valid, tmo, ovf}, cyc, edg);
        end
        rst_i     = 1'b0;
        doneCount = 0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk_i);
            if (done) doneCount++;
        end
        nChecks++;
        if (doneCount != 0) begin
            nFails++;
            $display("[TB] FAIL mid_reset_no_done: got %0d done pulses expected 0", doneCount);
        end
        idle(6);
        test_basic("restart");
    endtask

    task automatic test_freeze;
        int  waited;
        bit  seen;
        int  doneCount;
        buildPeriodic(3, 5, 5);
        applyStimulus(100);
        repeat (30) @(negedge clk_i);
        start_i = 1'b1;
        gate_i  = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        cke_i     = 1'b0;
        doneCount = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (done || !busy) doneCount++;
        end
        cke_i = 1'b1;
        nChecks++;
        if (doneCount != 0) begin
            nFails++;
            $display("[TB] FAIL freeze_hold: got %0d cycles not busy or done expected 0", doneCount);
        end
        waitDone(1'b0, 400, waited, seen);
        nChecks++;
        if (!seen || edg !== 32'd10 || cyc !== 32'd100 || tmo !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL freeze_result: got done=%b edges=%0d cycles=%0d tmo=%b expected 1/10/100/0",
                     seen, edg, cyc, tmo);
        end
        idle(6);
    endtask

    task automatic test_back_to_back;
        int  waited;
        bit  seen;
        int  expE, expC;
        bit  expT;
        buildPeriodic(3, 5, 5);
        applyStimulus(100);
        waitDone(1'b0, 400, waited, seen);
        start_i = 1'b1;
        gate_i  = 32'd60;
        gate8   = 8'd60;
        @(negedge clk_i);
        nChecks++;
        if (busy !== 1'b0 || valid !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL start_in_done: got busy=%b valid=%b expected 0/1", busy, valid);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        nChecks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL start_after_done: got busy=%b valid=%b expected 1/0", busy, valid);
        end
        modelMeasure(60, expE, expC, expT);
        waitDone(1'b0, 400, waited, seen);
        nChecks++;
        if (!seen || edg !== expE || cyc !== expC || tmo !== expT) begin
            nFails++;
            $display("[TB] FAIL back_to_back: got done=%b edges=%0d cycles=%0d tmo=%b expected 1/%0d/%0d/%b",
                     seen, edg, cyc, tmo, expE, expC, expT);
        end
        idle(6);
    endtask

    task automatic test_random;
        int  g, waited;
        bit  seen;
        int  expE, expC;
        bit  expT;
        for (int it = 0; it < 12; it++) begin
            g = $urandom_range(200, 12);
            buildRandom($urandom_range(4, 0), 9);
            modelMeasure(g, expE, expC, expT);
            applyStimulus(g);
            waitDone(1'b0, g + 60, waited, seen);
            nChecks++;
            if (!seen || edg !== expE || cyc !== expC || tmo !== expT || valid !== 1'b1 || ovf !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL random_%0d (G=%0d): got done=%b edges=%0d cycles=%0d tmo=%b valid=%b ovf=%b expected 1/%0d/%0d/%b/1/0",
                         it, g, seen, edg, cyc, tmo, valid, ovf, expE, expC, expT);
            end
            idle(6);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cke_i   = 1'b1;
        rst_i   = 1'b1;
        start_i = 1'b0;
        gate_i  = '0;
        gate8   = '0;
        test_reset();
        test_basic("basic");
        test_pattern();
        test_arm_timeout();
        test_narrow();
        test_reset_mid();
        test_freeze();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
